elastic_pipe2: RTL and testbench
================================

ELASTIC_PIPE2 -- requirements
Module: elastic_pipe2

Interface
REQ-001 Parameter WIDTH, default 64, sets the data path width in bits; legal range is 1 to 64.
REQ-002 Port clk, input, 1 bit: clock; all state SHALL update on its rising edge only.
REQ-003 Port rst_n, input, 1 bit: reset; synchronous, active-low; clock clk.
REQ-004 Port in_valid, input, 1 bit: upstream asserts it when in_data holds a word.
REQ-005 Port in_ready, output, 1 bit: the block SHALL assert it when it can accept a word this cycle.
REQ-006 Port in_data, input, WIDTH bits: upstream word.
REQ-007 Port out_valid, output, 1 bit: the block SHALL assert it when out_data holds a word.
REQ-008 Port out_ready, input, 1 bit: downstream asserts it when it can accept a word.
REQ-009 Port out_data, output, WIDTH bits: head word.
REQ-010 Port count, output, 2 bits: number of stored words, 0 to 2.

Function
REQ-011 The block SHALL hold two storage registers: slot0, which is the head and drives out_data, and slot1, which is the tail.
REQ-012 A push occurs on a cycle with in_valid=1 and in_ready=1; a pop occurs on a cycle with out_valid=1 and out_ready=1.
REQ-013 in_ready SHALL equal (count!=2) AND rst_n, decoded from registered state only, with no combinational path from out_ready or in_valid.
REQ-014 out_valid SHALL equal (count!=0), driven from a register.
REQ-015 out_data SHALL be driven by register slot0 with no combinational path from in_data.
REQ-016 Latency from push to out_valid SHALL be 1 cycle when count=0; the word is visible on the cycle after the accepting edge.
REQ-017 Push only, count=0: in_data SHALL be written to slot0 and count becomes 1.
REQ-018 Push only, count=1: in_data SHALL be written to slot1 and count becomes 2.
REQ-019 Pop only, count=2: slot1 SHALL move to slot0 and count becomes 1.
REQ-020 Pop only, count=1: count SHALL become 0; slot0 holds its stale value.
REQ-021 Push and pop together, count=1: in_data SHALL be written to slot0 and count stays 1.
REQ-022 Push and pop together cannot occur at count=0 (out_valid=0) or at count=2 (in_ready=0).
REQ-023 Full throughput: sustained in_valid=1 and out_ready=1 SHALL transfer one word per cycle with no bubbles after the first.
REQ-024 Word order SHALL be preserved: no word is lost, duplicated or reordered.
REQ-025 With in_valid=1 and in_ready=0, in_data SHALL be ignored; the upstream holds the word.
REQ-026 Once out_valid=1, out_data SHALL stay stable until a pop occurs.
REQ-027 count arithmetic SHALL saturate within 0..2 by construction; no wrap-around states are reachable.

Reset
REQ-028 While rst_n=0 at a rising clk edge: count SHALL become 0, out_valid 0, and slot0 and slot1 the value 1 zero-extended to WIDTH.
REQ-029 While rst_n=0, in_ready SHALL be 0 and no push SHALL occur.
REQ-030 Reset asserted mid-operation SHALL discard all stored words; no pop is reported on that edge.
REQ-031 On the first rising edge with rst_n=1, the block SHALL accept a push.

Verification
REQ-032 Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, count=0, out_data=4'h1 (WIDTH=4).
REQ-033 Single word: push 4'h3 with out_ready=0 -> next cycle out_valid=1, out_data=3, count=1; set out_ready=1 -> one cycle later count=0.
REQ-034 Fill and stall: push 3, 7, 5 on consecutive cycles with out_ready=0 -> 3 and 7 are accepted, count=2, in_ready=0, 5 is held; release out_ready -> outputs 3, 7, 5 in order.
REQ-035 Streaming: in_valid=1 and out_ready=1 for 8 cycles with data 0..7 -> out_data 0..7 on consecutive cycles starting 1 cycle after the first push, count=1 throughout.
REQ-036 Random: random in_valid and out_ready for 10k cycles against a scoreboard -> order preserved, count never exceeds 2, out_data stable while stalled.
REQ-037 Mid-reset: count=2 holding 2 and 4, assert rst_n=0 for 1 cycle -> count=0, out_valid=0; the next push of 4'h6 appears alone on out_data.

Source files
------------

// File: rtl/elastic_pipe2.sv
// elastic_pipe2: two-entry elastic buffer (skid pipe) between a valid/ready
// producer and consumer. slot0 is the head and drives out_data directly;
// slot1 catches the word that arrives while the head is stalled. in_ready
// depends only on stored state and rst_n, so no ready path runs through.
module elastic_pipe2 #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  localparam logic [WIDTH-1:0] RESET_WORD = WIDTH'(1'b1);
  localparam logic [1:0]       CNT_EMPTY  = 2'd0;
  localparam logic [1:0]       CNT_ONE    = 2'd1;
  localparam logic [1:0]       CNT_FULL   = 2'd2;

  logic [WIDTH-1:0] slot0_r;
  logic [WIDTH-1:0] slot1_r;
  logic [1:0]       count_r;
  logic             out_valid_r;

  logic [WIDTH-1:0] slot0_next_s;
  logic [WIDTH-1:0] slot1_next_s;
  logic [1:0]       count_next_s;
  logic             push_s;
  logic             pop_s;

  // Ready is decoded from the stored count only, gated low while in reset.
  assign in_ready  = (count_r != CNT_FULL) && rst_n;
  assign out_valid = out_valid_r;
  assign out_data  = slot0_r;
  assign count     = count_r;

  assign push_s = in_valid && in_ready;
  assign pop_s  = out_valid_r && out_ready;

  // Next-state decode for the two slots and the occupancy count.
  always_comb begin
    slot0_next_s = slot0_r;
    slot1_next_s = slot1_r;
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10: begin
        if (count_r == CNT_EMPTY) begin
          slot0_next_s = in_data;
          count_next_s = CNT_ONE;
        end else if (count_r == CNT_ONE) begin
          slot1_next_s = in_data;
          count_next_s = CNT_FULL;
        end else begin
          count_next_s = count_r;
        end
      end
      2'b01: begin
        if (count_r == CNT_FULL) begin
          slot0_next_s = slot1_r;
          count_next_s = CNT_ONE;
        end else if (count_r == CNT_ONE) begin
          // Head keeps its stale word; only the count drops.
          count_next_s = CNT_EMPTY;
        end else begin
          count_next_s = count_r;
        end
      end
      2'b11: begin
        // Simultaneous push and pop is only reachable with one word held:
        // the departing head is replaced by the incoming word.
        if (count_r == CNT_ONE) begin
          slot0_next_s = in_data;
          count_next_s = CNT_ONE;
        end else begin
          count_next_s = count_r;
        end
      end
      default: begin
        count_next_s = count_r;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot0_r     <= RESET_WORD;
      slot1_r     <= RESET_WORD;
      count_r     <= CNT_EMPTY;
      out_valid_r <= 1'b0;
    end else begin
      slot0_r     <= slot0_next_s;
      slot1_r     <= slot1_next_s;
      count_r     <= count_next_s;
      out_valid_r <= (count_next_s != CNT_EMPTY);
    end
  end

endmodule

// File: tb/tb_elastic_pipe2.sv
// Self-checking bench for elastic_pipe2 (WIDTH=4). A queue-based reference
// model holds the words the buffer should contain; the monitor compares the
// DUT outputs to it every cycle and retires words on each handshake.
module tb_elastic_pipe2;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = 4'h0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic [1:0]   count;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [W-1:0] sb[$];

  elastic_pipe2 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  // Cycle counter for latency/throughput measurements.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor + reference model: compare outputs to the model queue on the
  // falling edge, then apply the handshake that the next rising edge will see.
  initial begin : monitor
    bit after_reset = 1'b0;
    bit exp_ready;
    @(posedge clk);
    forever begin
      @(negedge clk);
      exp_ready = rst_n && (sb.size() < 2);
      check("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
      check("out_valid", {31'd0, out_valid}, {31'd0, (sb.size() != 0)});
      check("count", {30'd0, count}, sb.size());
      if (after_reset) check("reset_data", {28'd0, out_data}, 32'd1);
      if (sb.size() > 0) check("head_data", {28'd0, out_data}, {28'd0, sb[0]});
      if (!rst_n) begin
        sb.delete();
        after_reset = 1'b1;
      end else begin
        after_reset = 1'b0;
        if (sb.size() > 0 && out_ready) void'(sb.pop_front());
        if (in_valid && exp_ready) sb.push_back(in_data);
      end
    end
  end

  // Present a word and hold it until accepted; returns cycles spent.
  task automatic send(input logic [W-1:0] d, output int waited);
    bit acc = 1'b0;
    waited = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!acc && waited < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    check("send_accept", {31'd0, acc}, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Global watchdog so the run always terminates.
  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int w;
    int t0;
    bit acc;

    // Reset held for 3 cycles with in_valid asserted.
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_data = 4'hA;
    idle(3);
    // First edge out of reset must accept.
    rst_n = 1'b1;
    send(4'h9, w);
    check("first_push_latency", w, 32'd1);
    out_ready = 1'b1;
    idle(2);
    out_ready = 1'b0;

    // Single word, then drain.
    send(4'h3, w);
    idle(2);
    out_ready = 1'b1;
    idle(2);
    out_ready = 1'b0;

    // Fill and stall: 3 and 7 accepted, 5 held while full.
    send(4'h3, w);
    send(4'h7, w);
    in_valid = 1'b1;
    in_data  = 4'h5;
    repeat (3) begin
      @(negedge clk);
      check("full_stall_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(4'h5, w);
    idle(4);

    // Streaming: eight words on consecutive cycles.
    out_ready = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 8; i++) send(4'(i), w);
    check("stream_cycles", cyc - t0, 32'd8);
    idle(3);

    // Mid-operation reset with two words stored.
    out_ready = 1'b0;
    send(4'h2, w);
    send(4'h4, w);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    send(4'h6, w);
    idle(1);
    out_ready = 1'b1;
    idle(3);

    // Random traffic; the producer holds a word until it is accepted.
    in_valid = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc || !in_valid) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = 4'($urandom);
      end
      out_ready = 1'($urandom_range(0, 3) != 0);
    end

    // Drain whatever remains.
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle(4);
    @(negedge clk);
    check("final_empty", {30'd0, count}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
